// File: rtl/mon_pkg.sv
// mon_pkg: shared types and constants for test_result_monitor.
package mon_pkg;

  // Monitor sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Verdict raised by the inputs of a single RUN cycle.
  typedef enum logic [2:0] {
    VD_NONE    = 3'd0,
    VD_PASS    = 3'd1,
    VD_FAIL    = 3'd2,
    VD_TIMEOUT = 3'd3,
    VD_HANG    = 3'd4
  } verdict_e;

  // riscv-tests leave gp (and tohost) equal to 1 on a passing run.
  localparam int unsigned RVT_PASS = 1;

endpackage

// File: rtl/mon_loop_detect.sv
// mon_loop_detect: flags a core spinning on one PC.
// Keeps the last retired PC and a count of back-to-back repeats of it; the
// hang strobe fires on the retirement that makes LOOP_LIMIT identical
// retirements in a row. Cycles without a retirement leave the state alone.
module mon_loop_detect #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LOOP_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            pc_valid_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hang_o
);

  localparam int unsigned CW = $clog2(LOOP_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOOP_LIMIT - 1);

  logic [XLEN-1:0] prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            same_pc;

  assign same_pc = pc_valid_i && prev_vld_q && (pc_i == prev_q);
  assign cnt_inc = cnt_q + CW'(1);
  // The saturated term only matters if the top were to stay in RUN past a hang.
  assign hang_o  = en_i && same_pc && ((cnt_inc == CNT_MAX) || (cnt_q == CNT_MAX));

  // Track previous PC and repeat count; cleared when a new run begins.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    cnt_d      = cnt_q;
    if (clr_i) begin
      prev_d     = '0;
      prev_vld_d = 1'b0;
      cnt_d      = '0;
    end else if (en_i && pc_valid_i) begin
      prev_d     = pc_i;
      prev_vld_d = 1'b1;
      if (same_pc) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/test_result_monitor.sv
// test_result_monitor: end-of-test verdict for riscv-tests runs.
// Watches retired PC and gp and latches a sticky pass/fail/timeout/hang
// verdict. Define MON_TOHOST_EN to add the tohost store port and the
// TOHOST_ADDR parameter as an extra, highest-priority termination source.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | outputs zero, waiting for start
// ST_RUN  | counting cycles, evaluating verdict sources each cycle
// ST_DONE | verdict frozen, waiting for clear
module test_result_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] END_PC      = XLEN'(32'h44),
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     LOOP_LIMIT  = 16
`ifdef MON_TOHOST_EN
  ,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000)
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  gp,
`ifdef MON_TOHOST_EN
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
`endif
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic             hung,
  output logic [XLEN-2:0]  fail_test_num,
  output logic [CNT_W-1:0] cycle_count
);

  import mon_pkg::*;

  state_e           state_q, state_d;
  verdict_e         verdict;
  logic [XLEN-2:0]  vnum;
  logic             hang;
  logic             run_entry;
  logic             in_run;

  logic             done_q, done_d;
  logic             passed_q, passed_d;
  logic             failed_q, failed_d;
  logic             timed_out_q, timed_out_d;
  logic             hung_q, hung_d;
  logic [XLEN-2:0]  fnum_q, fnum_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  assign run_entry = (state_q == ST_IDLE) && start;
  assign in_run    = (state_q == ST_RUN);

  mon_loop_detect #(
    .XLEN       (XLEN),
    .LOOP_LIMIT (LOOP_LIMIT)
  ) u_loop_detect (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (run_entry),
    .en_i       (in_run),
    .pc_valid_i (pc_valid),
    .pc_i       (pc),
    .hang_o     (hang)
  );

  // Pick the highest-priority verdict raised by this cycle's inputs.
  always_comb begin
    verdict = VD_NONE;
    vnum    = '0;
`ifdef MON_TOHOST_EN
    if (st_valid && (st_addr == TOHOST_ADDR) && st_data[0]) begin
      verdict = (st_data == XLEN'(RVT_PASS)) ? VD_PASS : VD_FAIL;
      vnum    = st_data[XLEN-1:1];
    end else
`endif
    if (pc_valid && (pc == END_PC)) begin
      verdict = (gp == XLEN'(RVT_PASS)) ? VD_PASS : VD_FAIL;
      vnum    = gp[XLEN-1:1];
    end else if (hang) begin
      verdict = VD_HANG;
    end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
      verdict = VD_TIMEOUT;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    timed_out_d = timed_out_q;
    hung_d      = hung_q;
    fnum_d      = fnum_q;
    cycle_d     = cycle_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cycle_d = '0;
        end
      end
      ST_RUN: begin
        if (verdict != VD_NONE) begin
          // cycle_count stays at the value of the deciding cycle.
          state_d = ST_DONE;
          done_d  = 1'b1;
          case (verdict)
            VD_PASS:    passed_d    = 1'b1;
            VD_FAIL: begin
              failed_d = 1'b1;
              fnum_d   = vnum;
            end
            VD_TIMEOUT: timed_out_d = 1'b1;
            VD_HANG:    hung_d      = 1'b1;
            default:    ;
          endcase
        end else if (!(&cycle_q)) begin
          cycle_d = cycle_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d     = ST_IDLE;
          done_d      = 1'b0;
          passed_d    = 1'b0;
          failed_d    = 1'b0;
          timed_out_d = 1'b0;
          hung_d      = 1'b0;
          fnum_d      = '0;
          cycle_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
      hung_q      <= 1'b0;
      fnum_q      <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timed_out_q <= timed_out_d;
      hung_q      <= hung_d;
      fnum_q      <= fnum_d;
      cycle_q     <= cycle_d;
    end
  end

  assign done          = done_q;
  assign passed        = passed_q;
  assign failed        = failed_q;
  assign timed_out     = timed_out_q;
  assign hung          = hung_q;
  assign fail_test_num = fnum_q;
  assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// tb_test_result_monitor: randomized runs checked against a sequence-scanning
// reference model. Define MON_TOHOST_EN to also exercise the tohost port.
module tb_test_result_monitor;

  localparam int          XLEN       = 32;
  localparam int          CNT_W      = 32;
  localparam int          TIMEOUT    = 50;
  localparam int          LOOP_LIMIT = 16;
  localparam logic [31:0] END_PC     = 32'h44;
  localparam int          MAXN       = 128;
  localparam int          RUNLEN     = 60;
  localparam logic [3:0]  F_PASS     = 4'b1000;
  localparam logic [3:0]  F_FAIL     = 4'b0100;
  localparam logic [3:0]  F_TO       = 4'b0010;
  localparam logic [3:0]  F_HANG     = 4'b0001;
`ifdef MON_TOHOST_EN
  localparam logic [31:0] TOHOST     = 32'h1000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] gp = '0;
`ifdef MON_TOHOST_EN
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
`endif
  logic        done, passed, failed, timed_out, hung;
  logic [30:0] fail_test_num;
  logic [31:0] cycle_count;

  test_result_monitor #(
    .XLEN(XLEN), .END_PC(END_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .LOOP_LIMIT(LOOP_LIMIT)
`ifdef MON_TOHOST_EN
    , .TOHOST_ADDR(TOHOST)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .pc_valid(pc_valid), .pc(pc), .gp(gp),
`ifdef MON_TOHOST_EN
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
`endif
    .done(done), .passed(passed), .failed(failed), .timed_out(timed_out), .hung(hung),
    .fail_test_num(fail_test_num), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle stimulus of one run.
  logic        s_valid[MAXN];
  logic [31:0] s_pc[MAXN];
  logic [31:0] s_gp[MAXN];
`ifdef MON_TOHOST_EN
  logic        s_stv[MAXN];
  logic [31:0] s_sta[MAXN];
  logic [31:0] s_std[MAXN];
`endif
  int          g_end_idx;

  // Model expectation: RUN-cycle index of the deciding cycle and its verdict.
  int          e_idx;
  logic [3:0]  e_flags;
  logic [30:0] e_fnum;

  // Observations from the DUT during one run.
  int          o_first;
  logic        o_early;
  logic [3:0]  o_flags_first, o_flags_end;
  logic [30:0] o_fnum_first, o_fnum_end;
  logic [31:0] o_cc_first, o_cc_end;

  function automatic logic [3:0] flags_now();
    return {passed, failed, timed_out, hung};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      s_valid[i] = 1'b0;
      s_pc[i]    = $urandom;
      s_gp[i]    = $urandom;
`ifdef MON_TOHOST_EN
      s_stv[i]   = 1'b0;
      s_sta[i]   = '0;
      s_std[i]   = '0;
`endif
    end
  endtask

  // Scan the stimulus with the verdict rules and find the first deciding cycle.
  task automatic predict(input int n);
    int          streak;
    logic [31:0] last;
    bit          have;
    bit          hang_now;
    logic [3:0]  f;
    logic [30:0] fn;
    e_idx = -1; e_flags = '0; e_fnum = '0;
    streak = 0; have = 0; last = '0;
    for (int i = 0; i < n; i++) begin
      f = '0; fn = '0;
      if (s_valid[i]) begin
        if (have && s_pc[i] == last) streak++;
        else streak = 1;
        last = s_pc[i];
        have = 1;
      end
      hang_now = s_valid[i] && (streak == LOOP_LIMIT);
`ifdef MON_TOHOST_EN
      if (s_stv[i] && s_sta[i] == TOHOST && s_std[i][0]) begin
        if (s_std[i] == 32'd1) f = F_PASS;
        else begin f = F_FAIL; fn = s_std[i][31:1]; end
      end else
`endif
      if (s_valid[i] && s_pc[i] == END_PC) begin
        if (s_gp[i] == 32'd1) f = F_PASS;
        else begin f = F_FAIL; fn = s_gp[i][31:1]; end
      end else if (hang_now) f = F_HANG;
      else if (i == TIMEOUT - 1) f = F_TO;
      if (f != '0) begin
        e_idx = i; e_flags = f; e_fnum = fn;
        break;
      end
    end
  endtask

  // Start a run, apply n stimulus cycles, record what the DUT shows.
  task automatic drive_run(input int n, input int poke_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    o_first = -1; o_early = 1'b0;
    o_flags_first = 'x; o_fnum_first = 'x; o_cc_first = 'x;
    for (int i = 0; i < n; i++) begin
      pc_valid = s_valid[i]; pc = s_pc[i]; gp = s_gp[i];
`ifdef MON_TOHOST_EN
      st_valid = s_stv[i]; st_addr = s_sta[i]; st_data = s_std[i];
`endif
      start = (i == poke_at);
      clear = (i == poke_at);
      tick();
      if (done && o_first < 0) begin
        o_first = i; o_flags_first = flags_now();
        o_fnum_first = fail_test_num; o_cc_first = cycle_count;
      end
      if (!done && (flags_now() != '0 || fail_test_num != '0)) o_early = 1'b1;
    end
    pc_valid = 1'b0; start = 1'b0; clear = 1'b0;
`ifdef MON_TOHOST_EN
    st_valid = 1'b0;
`endif
    o_flags_end = flags_now(); o_fnum_end = fail_test_num; o_cc_end = cycle_count;
  endtask

  task automatic finish_run();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic gen_pass_fail(input logic [31:0] end_gp);
    logic [31:0] p;
    p = '0; g_end_idx = -1;
    clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      if (p <= END_PC && $urandom_range(0, 3) != 0) begin
        s_valid[i] = 1'b1;
        s_pc[i]    = p;
        if (p == END_PC) begin s_gp[i] = end_gp; g_end_idx = i; end
        p = p + 32'd4;
      end
    end
  endtask

  task automatic gen_hang(input bit insert, input bit bubbles);
    int r;
    r = 0;
    clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      if (!(bubbles && $urandom_range(0, 7) == 0)) begin
        s_valid[i] = 1'b1;
        s_pc[i]    = (insert && r == 9) ? 32'h3C : 32'h40;
        r++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_tests++;
    if ({done, passed, failed, timed_out, hung, fail_test_num, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: done=%b flags=%b num=%0d cc=%0d, expected all 0",
               done, flags_now(), fail_test_num, cycle_count);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({done, passed, failed, timed_out, hung, fail_test_num, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: done=%b flags=%b num=%0d cc=%0d, expected all 0",
               done, flags_now(), fail_test_num, cycle_count);
    end
  endtask

  task automatic test_pass_fail();
    logic [31:0] eg;
    for (int r = 0; r < 6; r++) begin
      if (r == 0) eg = 32'd1;
      else if (r == 1) eg = 32'd7;
      else if ($urandom_range(0, 1) == 0) eg = 32'd1;
      else eg = ($urandom_range(1, 500) << 1) | 32'd1;
      gen_pass_fail(eg);
      predict(RUNLEN);
      drive_run(RUNLEN, -1);
      n_tests++;
      if (o_first !== e_idx || o_early !== 1'b0) begin
        n_fail++;
        $display("FAIL pass_fail[%0d] edge: done at %0d early=%b, expected %0d early=0", r, o_first, o_early, e_idx);
      end
      n_tests++;
      if ({o_flags_first, o_fnum_first, o_cc_first} !== {e_flags, e_fnum, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL pass_fail[%0d] verdict: flags=%b num=%0d cc=%0d, expected flags=%b num=%0d cc=%0d",
                 r, o_flags_first, o_fnum_first, o_cc_first, e_flags, e_fnum, e_idx);
      end
      n_tests++;
      if ({o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL pass_fail[%0d] frozen: flags=%b num=%0d cc=%0d, expected flags=%b num=%0d cc=%0d",
                 r, o_flags_end, o_fnum_end, o_cc_end, e_flags, e_fnum, e_idx);
      end
      finish_run();
    end
  endtask

  task automatic test_hang();
    for (int r = 0; r < 4; r++) begin
      gen_hang(r != 0, r >= 2);
      predict(RUNLEN);
      drive_run(RUNLEN, -1);
      n_tests++;
      if (o_first !== e_idx || o_early !== 1'b0) begin
        n_fail++;
        $display("FAIL hang[%0d] edge: done at %0d early=%b, expected %0d early=0", r, o_first, o_early, e_idx);
      end
      n_tests++;
      if ({o_flags_first, o_fnum_first, o_cc_first} !== {e_flags, e_fnum, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL hang[%0d] verdict: flags=%b num=%0d cc=%0d, expected flags=%b num=%0d cc=%0d",
                 r, o_flags_first, o_fnum_first, o_cc_first, e_flags, e_fnum, e_idx);
      end
      n_tests++;
      if ({o_flags_end, o_cc_end} !== {e_flags, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL hang[%0d] frozen: flags=%b cc=%0d, expected flags=%b cc=%0d",
                 r, o_flags_end, o_cc_end, e_flags, e_idx);
      end
      finish_run();
    end
  endtask

  task automatic test_timeout_clear();
    clear_stim();
    predict(RUNLEN);
    drive_run(RUNLEN, 10);
    n_tests++;
    if (o_first !== e_idx || o_early !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout edge: done at %0d early=%b, expected %0d early=0", o_first, o_early, e_idx);
    end
    n_tests++;
    if ({o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
      n_fail++;
      $display("FAIL timeout verdict: flags=%b num=%0d cc=%0d, expected flags=%b num=%0d cc=%0d",
               o_flags_end, o_fnum_end, o_cc_end, e_flags, e_fnum, e_idx);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_tests++;
    if ({done, flags_now(), cycle_count} !== {1'b1, F_TO, 32'd49}) begin
      n_fail++;
      $display("FAIL start_in_done: done=%b flags=%b cc=%0d, expected done=1 flags=%b cc=49",
               done, flags_now(), cycle_count, F_TO);
    end
    finish_run();
    n_tests++;
    if ({done, passed, failed, timed_out, hung, fail_test_num, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL clear: done=%b flags=%b num=%0d cc=%0d, expected all 0",
               done, flags_now(), fail_test_num, cycle_count);
    end
    gen_pass_fail(32'd1);
    predict(RUNLEN);
    drive_run(RUNLEN, -1);
    n_tests++;
    if (o_first !== e_idx || {o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
      n_fail++;
      $display("FAIL rerun: done at %0d flags=%b cc=%0d, expected %0d flags=%b cc=%0d",
               o_first, o_flags_end, o_cc_end, e_idx, e_flags, e_idx);
    end
    finish_run();
  endtask

  task automatic test_priority();
    // Hang and timeout raised by the same cycle, then END and timeout.
    for (int r = 0; r < 2; r++) begin
      clear_stim();
      if (r == 0) begin
        for (int i = 34; i < TIMEOUT; i++) begin s_valid[i] = 1'b1; s_pc[i] = 32'h40; end
      end else begin
        s_valid[TIMEOUT-1] = 1'b1; s_pc[TIMEOUT-1] = END_PC; s_gp[TIMEOUT-1] = 32'd1;
      end
      predict(RUNLEN);
      drive_run(RUNLEN, -1);
      n_tests++;
      if (o_first !== e_idx || {o_flags_end, o_cc_end} !== {e_flags, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL priority[%0d]: done at %0d flags=%b cc=%0d, expected %0d flags=%b cc=%0d",
                 r, o_first, o_flags_end, o_cc_end, e_idx, e_flags, e_idx);
      end
      finish_run();
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    clear_stim();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc_valid = 1'b1; pc = 32'h100 + 32'(4 * i); gp = 32'd1;
      tick();
    end
    pc_valid = 1'b0;
    n_tests++;
    if (cycle_count !== 32'd20 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_count: cc=%0d done=%b, expected cc=20 done=0", cycle_count, done);
    end
    rst = 1'b1;
    #2;
    n_tests++;
    if ({done, flags_now(), fail_test_num, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_run_reset: done=%b flags=%b cc=%0d, expected all 0", done, flags_now(), cycle_count);
    end
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      pc_valid = 1'b1; pc = END_PC; gp = 32'd1;
      tick();
      if ({done, passed, failed, timed_out, hung, fail_test_num, cycle_count} !== '0) bad++;
    end
    pc_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL end_without_start: %0d cycles with nonzero outputs, expected 0", bad);
    end
    gen_pass_fail(32'd1);
    predict(RUNLEN);
    drive_run(RUNLEN, -1);
    n_tests++;
    if (o_first !== e_idx || {o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
      n_fail++;
      $display("FAIL after_reset: done at %0d flags=%b cc=%0d, expected %0d flags=%b cc=%0d",
               o_first, o_flags_end, o_cc_end, e_idx, e_flags, e_idx);
    end
    finish_run();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int r = 0; r < 20; r++) begin
      clear_stim();
      for (int i = 0; i < MAXN; i++) begin
        int k;
        s_valid[i] = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 63);
        if (r % 2 == 0) s_pc[i] = (k < 4) ? END_PC : (k < 40) ? 32'h40 : 32'h3C;
        else            s_pc[i] = (k < 1) ? END_PC : (k < 4) ? 32'h3C : 32'h40;
        s_gp[i] = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
      end
      predict(RUNLEN);
      drive_run(RUNLEN, -1);
      if (o_first !== e_idx || o_early !== 1'b0 ||
          {o_flags_first, o_fnum_first, o_cc_first} !== {e_flags, e_fnum, 32'(e_idx)} ||
          {o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
        bad++;
        $display("FAIL random[%0d]: done at %0d flags=%b num=%0d cc=%0d, expected %0d flags=%b num=%0d cc=%0d",
                 r, o_first, o_flags_end, o_fnum_end, o_cc_end, e_idx, e_flags, e_fnum, e_idx);
      end
      finish_run();
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

`ifdef MON_TOHOST_EN
  task automatic test_tohost();
    for (int r = 0; r < 3; r++) begin
      gen_pass_fail(32'd1);
      s_stv[0] = 1'b1; s_sta[0] = TOHOST;   s_std[0] = 32'h4;
      s_stv[1] = 1'b1; s_sta[1] = 32'h2000; s_std[1] = 32'h3;
      if (r == 0 && g_end_idx >= 0) begin
        s_stv[g_end_idx] = 1'b1; s_sta[g_end_idx] = TOHOST; s_std[g_end_idx] = 32'h5;
      end else if (r == 1) begin
        s_stv[5] = 1'b1; s_sta[5] = TOHOST; s_std[5] = 32'h1;
      end else if (r == 2) begin
        s_stv[7] = 1'b1; s_sta[7] = TOHOST; s_std[7] = ($urandom_range(1, 900) << 1) | 32'd1;
      end
      predict(RUNLEN);
      drive_run(RUNLEN, -1);
      n_tests++;
      if (o_first !== e_idx || {o_flags_end, o_fnum_end, o_cc_end} !== {e_flags, e_fnum, 32'(e_idx)}) begin
        n_fail++;
        $display("FAIL tohost[%0d]: done at %0d flags=%b num=%0d cc=%0d, expected %0d flags=%b num=%0d cc=%0d",
                 r, o_first, o_flags_end, o_fnum_end, o_cc_end, e_idx, e_flags, e_fnum, e_idx);
      end
      finish_run();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_fail();
    test_hang();
    test_timeout_clear();
    test_priority();
    test_reset_mid_run();
    test_random();
`ifdef MON_TOHOST_EN
    test_tohost();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_result_monitor.md
Name: test_result_monitor

Overview:
- Synthesizable end-of-test monitor for riscv-tests runs on the core.
- Watches retired PC and gp (x3), plus optionally the store bus, and decides pass, fail, timeout or hang with a sticky verdict.
- Sits beside the core in each test harness; the harness only polls done and writes the result file.
- Generalises the fixed "pc==0x44, x3==1" check: parametrised end PC, width and timeout, failing test number reporting, self-loop hang detection, optional tohost termination.

Parameters:
- XLEN, 32, width of pc/gp/data.
- END_PC, 32'h44, PC whose retirement ends the test.
- TIMEOUT, 5000, cycles in RUN before timeout verdict (≥2).
- CNT_W, 32, width of cycle counter.
- LOOP_LIMIT, 16, consecutive retirements of an identical PC (≠END_PC) that count as a hang (≥2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: begin monitoring (IDLE only)
- clear  in  1  pulse: return to IDLE from DONE
- pc_valid  in  1  instruction retired this cycle
- pc  in  XLEN  retired instruction PC
- gp  in  XLEN  current value of x3
- done  out  1  verdict available
- passed  out  1  gp==1 at END_PC
- failed  out  1  gp!=1 at END_PC
- timed_out  out  1  TIMEOUT reached
- hung  out  1  self-loop detected
- fail_test_num  out  XLEN-1  gp>>1 captured on fail
- cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (async, immediate): state=IDLE, all outputs 0, counters 0. Reset mid-RUN discards everything.
- States: IDLE → RUN on start; RUN → DONE on verdict; DONE → IDLE on clear. start is ignored outside IDLE, clear is ignored outside DONE.
- Entering RUN zeroes cycle_count and the loop counter.
- RUN: cycle_count increments every cycle and saturates at all-ones.
- Verdicts are evaluated each RUN cycle; the outputs register on the next edge (1-cycle latency from the qualifying input cycle). Exactly one verdict flag is set.
  - END: pc_valid && pc==END_PC. If gp==1, passed=1. Otherwise failed=1 and fail_test_num=gp[XLEN-1:1].
  - HANG: loop counter reaches LOOP_LIMIT-1 while pc_valid and pc equals the previous retired PC.
    - Loop counter resets on any different PC.
    - Cycles without pc_valid leave it unchanged.
  - TIMEOUT: cycle_count==TIMEOUT-1.
- Priority on simultaneous events: tohost (if enabled) > END > HANG > TIMEOUT.
- DONE: done=1, all flags, fail_test_num and cycle_count are frozen and inputs are ignored. clear drops every output to 0 on the next edge.
- done rises in the same edge as the verdict flag.

Optional Feature:
- MON_TOHOST_EN defined adds ports:
  - st_valid in 1
  - st_addr in XLEN
  - st_data in XLEN
  - and parameter TOHOST_ADDR (default 32'h1000).
- In RUN, st_valid && st_addr==TOHOST_ADDR && st_data[0]==1 terminates the test:
  - st_data==1 gives passed.
  - Otherwise failed with fail_test_num=st_data[XLEN-1:1].
- Stores with st_data[0]==0 are ignored.
- Undefined: ports and parameter are absent; only the END/HANG/TIMEOUT sources exist.

Decomposition:
- Package mon_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - verdict encoding (NONE, PASS, FAIL, TIMEOUT, HANG)
  - the riscv-tests pass constant 1
- One sub-module, mon_loop_detect: previous-PC register plus loop counter; outputs a hang strobe.

Test Plan:
- start, then retire pc 0x0,0x4,…,0x44 with gp=1 → passed=1, done=1 one edge after the 0x44 cycle; cycle_count frozen.
- As above but gp=0x7 at 0x44 → failed=1, fail_test_num=3, passed=0.
- start, retire 0x40 twenty times consecutively (LOOP_LIMIT=16) → hung=1 after the 16th identical retirement; a 0x3C retirement inserted at retirement 10 delays hung accordingly.
- start, no pc_valid for TIMEOUT=50 cycles → timed_out=1, cycle_count=49; clear → all outputs 0, state IDLE; start again → fresh run.
- Apply rst mid-RUN at cycle 20, then end at 0x44 without start → no verdict, all outputs 0; ordering start after reset works normally.
- MON_TOHOST_EN: store st_data=0x5 to 0x1000 in the same cycle as pc=0x44/gp=1 → failed=1, fail_test_num=2 (tohost priority); a store of 0x4 has no effect.
